// File: rtl/nes_io_pkg.sv
// rtl/nes_io_pkg.sv - shared addresses, button indices and poller state type for the joypad port
package nes_io_pkg;

    localparam logic [15:0] JOY0_ADDR = 16'h4016;
    localparam logic [15:0] JOY1_ADDR = 16'h4017;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Ticks the latch pulse is held; the idle counter doubles as its timer.
    localparam int LATCH_TICKS = 2;

    // Wide enough for POLL_TICKS well beyond the 256 default.
    localparam int IDLE_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        READ_LO,
        READ_HI,
        COMMIT
    } pollState_e;

endpackage

// File: rtl/joypad_port_if.sv
// rtl/joypad_port_if.sv - CPU-side address/data/strobe bus as seen by the joypad port
interface joypad_port_if;
    logic        ce;
    logic [15:0] ain;
    logic [7:0]  din;
    logic        mr;
    logic        mw;
    logic [7:0]  dout;
    logic        dout_sel;

    modport master (
        output ce, ain, din, mr, mw,
        input  dout, dout_sel
    );

    modport slave (
        input  ce, ain, din, mr, mw,
        output dout, dout_sel
    );
endinterface

// File: rtl/joypad_port_pad_poller.sv
// rtl/joypad_port_pad_poller.sv - periodic serial poll of both pads with atomic commit
module pad_poller
    import nes_io_pkg::*;
#(
    parameter int TICK_DIV   = 128,
    parameter int POLL_TICKS = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons0,
    output logic [7:0] buttons1
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0]     TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST  = IDLE_CNT_W'(POLL_TICKS - 1);
    localparam logic [IDLE_CNT_W-1:0] LATCH_LAST = IDLE_CNT_W'(LATCH_TICKS - 1);

    logic [TICK_W-1:0]     tickCnt;
    logic                  tick;
    pollState_e            state, stateNext;
    logic [IDLE_CNT_W-1:0] idleCnt, idleNext;
    logic [2:0]            bitIdx, bitNext;
    logic [7:0]            cap0, cap1, cap0Next, cap1Next;
    logic [7:0]            btn0Next, btn1Next;

    assign tick = (tickCnt == TICK_LAST);

    // Free-running pad-timing divider; its phase is independent of the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            tickCnt <= '0;
        end else if (tick) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + TICK_W'(1);
        end
    end

    // Poller state, counters, capture and committed button registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idleCnt  <= '0;
            bitIdx   <= '0;
            cap0     <= '0;
            cap1     <= '0;
            buttons0 <= '0;
            buttons1 <= '0;
        end else begin
            state    <= stateNext;
            idleCnt  <= idleNext;
            bitIdx   <= bitNext;
            cap0     <= cap0Next;
            cap1     <= cap1Next;
            buttons0 <= btn0Next;
            buttons1 <= btn1Next;
        end
    end

    // Next-state logic: every phase but COMMIT waits for a tick to advance.
    always_comb begin
        stateNext = state;
        idleNext  = idleCnt;
        bitNext   = bitIdx;
        cap0Next  = cap0;
        cap1Next  = cap1;
        btn0Next  = buttons0;
        btn1Next  = buttons1;
        case (state)
            IDLE: begin
                if (tick) begin
                    if (idleCnt == IDLE_LAST) begin
                        idleNext  = '0;
                        stateNext = LATCH;
                    end else begin
                        idleNext = idleCnt + IDLE_CNT_W'(1);
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    if (idleCnt == LATCH_LAST) begin
                        idleNext  = '0;
                        stateNext = READ_LO;
                    end else begin
                        idleNext = idleCnt + IDLE_CNT_W'(1);
                    end
                end
            end
            READ_LO: begin
                if (tick) begin
                    cap0Next[bitIdx] = ~pad_data[0];
                    cap1Next[bitIdx] = ~pad_data[1];
                    stateNext        = READ_HI;
                end
            end
            READ_HI: begin
                if (tick) begin
                    // 3-bit index wraps to 0 exactly as the frame exits to COMMIT.
                    bitNext   = bitIdx + 3'd1;
                    stateNext = (bitIdx == 3'd7) ? COMMIT : READ_LO;
                end
            end
            COMMIT: begin
                btn0Next  = cap0;
                btn1Next  = cap1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign pad_latch = (state == LATCH);
    assign pad_clk   = (state == READ_HI);

endmodule

// File: rtl/joypad_port.sv
// rtl/joypad_port.sv - $4016/$4017 controller port responder with 4021-style shift readout
module joypad_port
    import nes_io_pkg::*;
#(
    parameter int TICK_DIV   = 128,
    parameter int POLL_TICKS = 256
) (
    input  logic                clk,
    input  logic                reset,
    joypad_port_if.slave        bus,
    output logic                pad_latch,
    output logic                pad_clk,
    input  logic [1:0]          pad_data,
    output logic [7:0]          buttons0,
    output logic [7:0]          buttons1
);

    logic       strobe;
    logic [7:0] sr0, sr1;
    logic       hit0, hit1;
    logic       rd0, rd1;
    logic       readBit;

    assign hit0 = (bus.ain == JOY0_ADDR);
    assign hit1 = (bus.ain == JOY1_ADDR);
    assign rd0  = hit0 & bus.mr & bus.ce;
    assign rd1  = hit1 & bus.mr & bus.ce;

    pad_poller #(
        .TICK_DIV   (TICK_DIV),
        .POLL_TICKS (POLL_TICKS)
    ) u_poller (
        .clk       (clk),
        .reset     (reset),
        .pad_data  (pad_data),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .buttons0  (buttons0),
        .buttons1  (buttons1)
    );

    // Strobe follows bit 0 of writes to $4016; $4017 writes belong to the APU.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobe <= 1'b0;
        end else if (bus.ce && bus.mw && hit0) begin
            strobe <= bus.din[0];
        end
    end

    // Shift registers reload continuously under strobe, otherwise shift in 1s on reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr0 <= 8'hFF;
            sr1 <= 8'hFF;
        end else if (strobe) begin
            sr0 <= buttons0;
            sr1 <= buttons1;
        end else begin
            if (rd0) begin
                sr0 <= {1'b1, sr0[7:1]};
            end
            if (rd1) begin
                sr1 <= {1'b1, sr1[7:1]};
            end
        end
    end

    // Read mux: under strobe the live A button shows through, otherwise the shifter LSB.
    always_comb begin
        readBit = 1'b0;
        if (hit1) begin
            readBit = strobe ? buttons1[BTN_A] : sr1[0];
        end else begin
            readBit = strobe ? buttons0[BTN_A] : sr0[0];
        end
        bus.dout     = 8'h40 | {7'b0, readBit};
        bus.dout_sel = bus.mr & (hit0 | hit1);
    end

endmodule

// File: tb/tb_joypad_port.sv
// tb/tb_joypad_port.sv - directed vector bench for joypad_port
module tb_joypad_port;

    localparam int TICK_DIV   = 4;
    localparam int POLL_TICKS = 20;

    typedef struct {
        logic        ce;
        logic [15:0] ain;
        logic [7:0]  din;
        logic        mr;
        logic        mw;
        logic [7:0]  expDout;
        logic        expSel;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       pad_latch, pad_clk;
    logic [1:0] pad_data;
    logic [7:0] buttons0, buttons1;

    logic [7:0] pad0Bits, pad1Bits;
    logic [3:0] padIdx;
    logic       padClkQ;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    joypad_port_if busIf ();

    joypad_port #(
        .TICK_DIV   (TICK_DIV),
        .POLL_TICKS (POLL_TICKS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (busIf),
        .pad_latch (pad_latch),
        .pad_clk   (pad_clk),
        .pad_data  (pad_data),
        .buttons0  (buttons0),
        .buttons1  (buttons1)
    );

    always #5 clk = ~clk;

    // Pad model: latch resets the bit pointer, each pad_clk rise advances it.
    always @(posedge clk) begin
        padClkQ <= pad_clk;
        if (pad_latch) begin
            padIdx <= 4'd0;
        end else if (pad_clk && !padClkQ && padIdx < 4'd8) begin
            padIdx <= padIdx + 4'd1;
        end
    end

    assign pad_data[0] = (padIdx < 4'd8) ? ~pad0Bits[padIdx[2:0]] : 1'b1;
    assign pad_data[1] = (padIdx < 4'd8) ? ~pad1Bits[padIdx[2:0]] : 1'b1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic ce, input logic [15:0] ain, input logic [7:0] din,
                          input logic mr, input logic mw, input logic [7:0] expDout,
                          input logic expSel);
        vec_t v;
        v.ce = ce; v.ain = ain; v.din = din; v.mr = mr; v.mw = mw;
        v.expDout = expDout; v.expSel = expSel;
        vecs.push_back(v);
    endtask

    task automatic busIdle();
        busIf.ce  = 1'b1;
        busIf.ain = 16'h0000;
        busIf.din = 8'h00;
        busIf.mr  = 1'b0;
        busIf.mw  = 1'b0;
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            busIf.ce  = vecs[i].ce;
            busIf.ain = vecs[i].ain;
            busIf.din = vecs[i].din;
            busIf.mr  = vecs[i].mr;
            busIf.mw  = vecs[i].mw;
            #1;
            check($sformatf("%s[%0d].dout", tag, i), busIf.dout, vecs[i].expDout);
            check($sformatf("%s[%0d].sel", tag, i), {7'b0, busIf.dout_sel}, {7'b0, vecs[i].expSel});
        end
        @(negedge clk);
        busIdle();
        vecs.delete();
    endtask

    task automatic waitButtons(input string name, input logic [7:0] exp0, input logic [7:0] exp1);
        int n = 0;
        while (buttons0 !== exp0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, ".buttons0"}, buttons0, exp0);
        check({name, ".buttons1"}, buttons1, exp1);
    endtask

    initial begin
        int n;
        int w;
        int rises;
        logic prev;

        busIdle();
        pad0Bits = 8'h09;
        pad1Bits = 8'h81;
        padIdx   = 4'd8;
        padClkQ  = 1'b0;
        reset    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.dout", busIf.dout, 8'h41);
        check("rst.sel", {7'b0, busIf.dout_sel}, 8'h00);
        check("rst.buttons0", buttons0, 8'h00);
        check("rst.buttons1", buttons1, 8'h00);
        check("rst.latch", {7'b0, pad_latch}, 8'h00);
        check("rst.padclk", {7'b0, pad_clk}, 8'h00);
        reset = 1'b0;

        // Idle shift register reads back all ones and keeps doing so.
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h0000, 8'h00, 0, 0, 8'h41, 0);
        addVec(1, 16'h4015, 8'h00, 1, 0, 8'h41, 0);
        runTable("idle");

        waitButtons("frame1", 8'h09, 8'h81);

        addVec(1, 16'h4016, 8'h01, 0, 1, 8'h41, 0);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h4017, 8'h00, 0, 1, 8'h41, 0);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h4016, 8'h00, 0, 1, 8'h41, 0);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4016, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h41, 1);
        addVec(0, 16'h4017, 8'h00, 1, 0, 8'h40, 1);
        addVec(0, 16'h4017, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h40, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h41, 1);
        addVec(1, 16'h4017, 8'h00, 1, 0, 8'h41, 1);
        runTable("serial");

        // Opposite patterns on both pads, commit must land on one clock.
        pad0Bits = 8'hFF;
        pad1Bits = 8'h00;
        n = 0;
        while (!pad_latch && n < 1000) begin
            @(negedge clk);
            n++;
        end
        w = 0;
        while (pad_latch && w < 100) begin
            w++;
            @(negedge clk);
        end
        check("latch.width", 8'(w), 8'(2 * TICK_DIV));
        waitButtons("frame2", 8'hFF, 8'h00);

        // Abort a frame in the HI half of bit 4.
        pad0Bits = 8'h5A;
        pad1Bits = 8'hA5;
        rises = 0;
        prev  = pad_clk;
        n     = 0;
        while (rises < 5 && n < 2000) begin
            @(negedge clk);
            n++;
            if (pad_clk && !prev) rises++;
            prev = pad_clk;
        end
        check("abort.reached", {7'b0, pad_clk}, 8'h01);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort.padclk", {7'b0, pad_clk}, 8'h00);
        check("abort.latch", {7'b0, pad_latch}, 8'h00);
        check("abort.buttons0", buttons0, 8'h00);
        check("abort.buttons1", buttons1, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (pad_latch) break;
        end
        check("abort.idlewait", 8'(n), 8'(POLL_TICKS * TICK_DIV));
        check("abort.noearly", buttons0, 8'h00);
        waitButtons("frame3", 8'h5A, 8'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
